// File: rtl/msrv32_pc_unit.sv
// Program-counter stage: picks the next fetch address (boot, trap, mepc return,
// branch/jump target or PC+4), holds the architectural PC and stalls on bus wait states.
module msrv32_pc_unit #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int unsigned XLEN         = 32
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic [XLEN-1:0] i_adder_in,
  input  logic            branch_taken_in,
  input  logic [1:0]      pc_src_in,
  input  logic [XLEN-1:0] epc_in,
  input  logic [XLEN-1:0] trap_address_in,
  input  logic            ahb_ready_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_4_out,
  output logic [XLEN-1:0] i_addr_out,
  output logic            misaligned_instr_out,
  output logic [XLEN-1:0] misaligned_addr_out,
  output logic            flush_out,
  output logic            instr_valid_out
);

  typedef enum logic {
    ST_BOOT,
    ST_RUN
  } state_t;

  typedef enum logic [1:0] {
    SRC_BOOT   = 2'b00,
    SRC_EPC    = 2'b01,
    SRC_TRAP   = 2'b10,
    SRC_NORMAL = 2'b11
  } pc_src_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] maddr_q, maddr_d;
  logic            flush_q, flush_d;
  logic            valid_q, valid_d;

  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] pc_plus_4;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pc_mux;
  logic            misaligned;
  logic            redirect;
  pc_src_t         src;

  always_comb begin
    src        = pc_src_t'(pc_src_in);
    tgt        = {i_adder_in[XLEN-1:1], 1'b0};
    pc_plus_4  = pc_q + XLEN'(4);
    next_pc    = branch_taken_in ? tgt : pc_plus_4;
    // Only a normal-flow taken target can be misaligned; traps/returns win over it.
    misaligned = branch_taken_in & tgt[1] & (src == SRC_NORMAL) & (state_q == ST_RUN);

    case (src)
      SRC_BOOT: pc_mux = BOOT_ADDRESS;
      SRC_EPC:  pc_mux = epc_in;
      SRC_TRAP: pc_mux = trap_address_in;
      default:  pc_mux = misaligned ? pc_q : next_pc;
    endcase

    redirect = (src != SRC_NORMAL) | (branch_taken_in & ~misaligned) | misaligned;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    maddr_d = maddr_q;
    flush_d = flush_q;
    valid_d = valid_q;
    if (state_q == ST_BOOT) begin
      // Boot cycle fetches BOOT_ADDRESS; that word becomes the first valid instruction.
      state_d = ST_RUN;
      pc_d    = BOOT_ADDRESS;
      flush_d = 1'b0;
      valid_d = 1'b1;
    end else if (ahb_ready_in) begin
      pc_d    = pc_mux;
      flush_d = redirect;
      valid_d = ~redirect;
      if (misaligned) begin
        maddr_d = tgt;
      end
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q <= ST_BOOT;
      pc_q    <= BOOT_ADDRESS;
      maddr_q <= '0;
      flush_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      maddr_q <= maddr_d;
      flush_q <= flush_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out               = pc_q;
  assign pc_plus_4_out        = pc_plus_4;
  assign i_addr_out           = (state_q == ST_RUN) ? pc_mux : BOOT_ADDRESS;
  assign misaligned_instr_out = misaligned;
  assign misaligned_addr_out  = maddr_q;
  assign flush_out            = flush_q;
  assign instr_valid_out      = valid_q;

endmodule

// File: tb/tb_msrv32_pc_unit.sv
// Bench for msrv32_pc_unit: directed vector table, async-reset sequence and
// randomized run against a behavioural model of the fetch-address rules.
module tb_msrv32_pc_unit;

  localparam logic [31:0] BOOT = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic [31:0] adder;
  logic        taken;
  logic [1:0]  src;
  logic [31:0] epc;
  logic [31:0] trap;
  logic        rdy;
  logic [31:0] pc_out, pc_plus_4_out, i_addr_out, maddr_out;
  logic        mis_out, flush_out, valid_out;

  int checks   = 0;
  int failures = 0;

  msrv32_pc_unit #(.BOOT_ADDRESS(BOOT), .XLEN(32)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .i_adder_in           (adder),
    .branch_taken_in      (taken),
    .pc_src_in            (src),
    .epc_in               (epc),
    .trap_address_in      (trap),
    .ahb_ready_in         (rdy),
    .pc_out               (pc_out),
    .pc_plus_4_out        (pc_plus_4_out),
    .i_addr_out           (i_addr_out),
    .misaligned_instr_out (mis_out),
    .misaligned_addr_out  (maddr_out),
    .flush_out            (flush_out),
    .instr_valid_out      (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus plus the expected combinational and post-edge values.
  typedef struct {
    logic        rdy;
    logic [1:0]  src;
    logic        taken;
    logic [31:0] adder;
    logic [31:0] epc;
    logic [31:0] trap;
    logic [31:0] e_iaddr;
    logic        e_mis;
    logic [31:0] e_pc;
    logic        e_flush;
    logic        e_valid;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] s, input logic t, input logic [31:0] a,
                     input logic [31:0] e, input logic [31:0] tr, input logic [31:0] ia,
                     input logic m, input logic [31:0] p, input logic f, input logic v,
                     input logic [31:0] ma);
    vec_t x;
    x = '{r, s, t, a, e, tr, ia, m, p, f, v, ma};
    vecs.push_back(x);
  endtask

  // Behavioural model: architectural PC plus the registered status bits.
  logic        m_run;
  logic [31:0] m_pc, m_maddr;
  logic        m_flush, m_valid;

  task automatic model_reset();
    m_run = 1'b0; m_pc = BOOT; m_maddr = 32'h0; m_flush = 1'b1; m_valid = 1'b0;
  endtask

  task automatic model_comb(output logic [31:0] iaddr, output logic mis);
    logic [31:0] t;
    t   = adder & 32'hFFFF_FFFE;
    mis = m_run && rst_n && src == 2'd3 && taken && (t % 4 != 0);
    if (!m_run || !rst_n)  iaddr = BOOT;
    else if (src == 2'd0)  iaddr = BOOT;
    else if (src == 2'd1)  iaddr = epc;
    else if (src == 2'd2)  iaddr = trap;
    else if (mis)          iaddr = m_pc;
    else if (taken)        iaddr = t;
    else                   iaddr = m_pc + 32'd4;
  endtask

  task automatic model_edge();
    logic [31:0] ia;
    logic        mis;
    model_comb(ia, mis);
    if (!m_run) begin
      m_run = 1'b1; m_pc = BOOT; m_flush = 1'b0; m_valid = 1'b1;
    end else if (rdy) begin
      m_pc    = ia;
      m_flush = (src != 2'd3) || taken;
      m_valid = !m_flush;
      if (mis) m_maddr = adder & 32'hFFFF_FFFE;
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, " pc_out"}, pc_out, m_pc);
    chk({tag, " flush_out"}, {31'b0, flush_out}, {31'b0, m_flush});
    chk({tag, " instr_valid_out"}, {31'b0, valid_out}, {31'b0, m_valid});
    chk({tag, " misaligned_addr_out"}, maddr_out, m_maddr);
  endtask

  task automatic check_comb(input string tag);
    logic [31:0] ia;
    logic        mis;
    model_comb(ia, mis);
    chk({tag, " i_addr_out"}, i_addr_out, ia);
    chk({tag, " misaligned_instr_out"}, {31'b0, mis_out}, {31'b0, mis});
    chk({tag, " pc_plus_4_out"}, pc_plus_4_out, m_pc + 32'd4);
  endtask

  logic [31:0] prev_pc;

  initial begin
    rst_n = 1'b0; rdy = 1'b1; src = 2'd3; taken = 1'b1; adder = 32'h2;
    epc = 32'h0; trap = 32'h0;

    // rdy, src, taken, adder, epc, trap | i_addr, mis | pc, flush, valid, maddr
    add(1, 2'd3, 0, 32'h0,   32'h0,         32'h0,   32'h100,       0, 32'h100,       0, 1, 32'h0);
    add(1, 2'd3, 0, 32'h0,   32'h0,         32'h0,   32'h104,       0, 32'h104,       0, 1, 32'h0);
    add(1, 2'd3, 0, 32'h0,   32'h0,         32'h0,   32'h108,       0, 32'h108,       0, 1, 32'h0);
    add(1, 2'd3, 0, 32'h0,   32'h0,         32'h0,   32'h10C,       0, 32'h10C,       0, 1, 32'h0);
    add(0, 2'd3, 0, 32'h0,   32'h0,         32'h0,   32'h110,       0, 32'h10C,       0, 1, 32'h0);
    add(0, 2'd3, 0, 32'h0,   32'h0,         32'h0,   32'h110,       0, 32'h10C,       0, 1, 32'h0);
    add(1, 2'd3, 0, 32'h0,   32'h0,         32'h0,   32'h110,       0, 32'h110,       0, 1, 32'h0);
    add(1, 2'd1, 0, 32'h0,   32'h10,        32'h0,   32'h10,        0, 32'h10,        1, 0, 32'h0);
    add(1, 2'd3, 1, 32'h42,  32'h0,         32'h0,   32'h10,        1, 32'h10,        1, 0, 32'h42);
    add(1, 2'd3, 1, 32'h41,  32'h0,         32'h0,   32'h40,        0, 32'h40,        1, 0, 32'h42);
    add(1, 2'd3, 0, 32'h0,   32'h0,         32'h0,   32'h44,        0, 32'h44,        0, 1, 32'h42);
    add(1, 2'd2, 1, 32'h302, 32'h0,         32'h200, 32'h200,       0, 32'h200,       1, 0, 32'h42);
    add(1, 2'd1, 0, 32'h0,   32'hFFFF_FFFC, 32'h0,   32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 0, 32'h42);
    add(1, 2'd3, 0, 32'h0,   32'h0,         32'h0,   32'h0,         0, 32'h0,         0, 1, 32'h42);
    add(0, 2'd3, 1, 32'h86,  32'h0,         32'h0,   32'h0,         1, 32'h0,         0, 1, 32'h42);
    add(1, 2'd0, 0, 32'h0,   32'h0,         32'h0,   32'h100,       0, 32'h100,       1, 0, 32'h42);
    add(1, 2'd1, 0, 32'h0,   32'h80,        32'h0,   32'h80,        0, 32'h80,        1, 0, 32'h42);

    // Reset held three cycles with a misaligned-looking request on the inputs.
    repeat (3) @(posedge clk);
    #2;
    chk("reset pc_out", pc_out, BOOT);
    chk("reset flush_out", {31'b0, flush_out}, 32'd1);
    chk("reset instr_valid_out", {31'b0, valid_out}, 32'd0);
    chk("reset misaligned_addr_out", maddr_out, 32'h0);
    chk("reset i_addr_out", i_addr_out, BOOT);
    chk("reset misaligned_instr_out", {31'b0, mis_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    prev_pc = BOOT;
    foreach (vecs[i]) begin
      rdy = vecs[i].rdy; src = vecs[i].src; taken = vecs[i].taken;
      adder = vecs[i].adder; epc = vecs[i].epc; trap = vecs[i].trap;
      #1;
      chk($sformatf("vec%0d i_addr_out", i), i_addr_out, vecs[i].e_iaddr);
      chk($sformatf("vec%0d misaligned_instr_out", i), {31'b0, mis_out}, {31'b0, vecs[i].e_mis});
      chk($sformatf("vec%0d pc_plus_4_out", i), pc_plus_4_out, prev_pc + 32'd4);
      @(posedge clk); #1;
      chk($sformatf("vec%0d pc_out", i), pc_out, vecs[i].e_pc);
      chk($sformatf("vec%0d flush_out", i), {31'b0, flush_out}, {31'b0, vecs[i].e_flush});
      chk($sformatf("vec%0d instr_valid_out", i), {31'b0, valid_out}, {31'b0, vecs[i].e_valid});
      chk($sformatf("vec%0d misaligned_addr_out", i), maddr_out, vecs[i].e_maddr);
      prev_pc = vecs[i].e_pc;
    end

    // Asynchronous reset between edges while stalled at pc 0x80.
    rdy = 1'b0; src = 2'd3; taken = 1'b0;
    #2;
    chk("stall pc_out before reset", pc_out, 32'h80);
    rst_n = 1'b0;
    #1;
    chk("async reset pc_out", pc_out, BOOT);
    chk("async reset flush_out", {31'b0, flush_out}, 32'd1);
    chk("async reset instr_valid_out", {31'b0, valid_out}, 32'd0);
    chk("async reset misaligned_addr_out", maddr_out, 32'h0);
    chk("async reset i_addr_out", i_addr_out, BOOT);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // Randomized run with occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      src   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 2)) : 2'd3;
      taken = $urandom_range(0, 2) == 0;
      adder = {$urandom_range(0, 255) << 8, 8'($urandom)};
      if ($urandom_range(0, 40) == 0) adder = 32'hFFFF_FFFF;
      epc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      trap  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 49) == 0) begin
        #1 rst_n = 1'b0;
        #1 model_reset();
        check_regs($sformatf("rnd%0d async reset", n));
        #1 rst_n = 1'b1;
      end
      #1;
      check_comb($sformatf("rnd%0d", n));
      @(posedge clk);
      model_edge();
      #1;
      check_regs($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
